// File: rtl/spi_pkg.sv
// Shared SPI constants: default frame shape, FSM state encoding and the
// mode-bit layout that the master-side register block uses as well.
package spi_pkg;

    localparam int         DATA_WIDTH_DEF = 8;
    localparam logic [7:0] IDLE_WORD_DEF  = 8'hFF;

    localparam int MODE_CPHA_BIT = 0;
    localparam int MODE_CPOL_BIT = 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall detect
// taken against a one-cycle-delayed copy of the synchronized level.
module spi_sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled SCK/MOSI/SlaveSelect_n, all four modes,
// MSB first, one-word transmit holding register and received-word strobe.
//
//   state     | meaning
//   ST_IDLE   | deselected, MISO tristated, waiting for SlaveSelect_n fall
//   ST_ACTIVE | selected, shifting words until SlaveSelect_n rises
module spi_slave
    import spi_pkg::*;
#(
    parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD   = DATA_WIDTH'(IDLE_WORD_DEF),
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  CPol,
    input  logic                  CPha,
    input  logic [DATA_WIDTH-1:0] TxData,
    input  logic                  TxWr,
    output logic                  TxReady,
    output logic [DATA_WIDTH-1:0] RxData,
    output logic                  RxValid,
    output logic                  TxUnderrun,
    output logic                  Abort,
    output logic                  Busy,
    input  logic                  SCK,
    input  logic                  MOSI,
    input  logic                  SlaveSelect_n,
    output logic                  MISO,
    output logic                  MisoOe
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CW     = $clog2(DATA_WIDTH + 1);

    logic sck_lvl_unused, sck_rise, sck_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
    logic ss_lvl_unused, ss_rise, ss_fall;

    spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_sck (
        .clk_i(Clk), .rst_i(Rst), .din_i(SCK),
        .level_o(sck_lvl_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i(Clk), .rst_i(Rst), .din_i(MOSI),
        .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_ss (
        .clk_i(Clk), .rst_i(Rst), .din_i(SlaveSelect_n),
        .level_o(ss_lvl_unused), .rise_o(ss_rise), .fall_o(ss_fall)
    );

    spi_state_e            state_q;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] tx_sr_q, rx_sr_q, hold_q, rx_data_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  hold_full_q, skip_shift_q, word_done_q;
    logic                  rx_valid_q, underrun_q, abort_q, busy_q, miso_oe_q;

    logic                  lead_edge_d, trail_edge_d;
    logic [DATA_WIDTH-1:0] tx_load_d;

    assign lead_edge_d  = mode_q[MODE_CPOL_BIT] ? sck_fall : sck_rise;
    assign trail_edge_d = mode_q[MODE_CPOL_BIT] ? sck_rise : sck_fall;
    assign tx_load_d    = hold_full_q ? hold_q : IDLE_WORD;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'b00;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            hold_q       <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            hold_full_q  <= 1'b0;
            skip_shift_q <= 1'b0;
            word_done_q  <= 1'b0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            // A write in a load cycle stays pending; the load itself uses the old content.
            if (TxWr) begin
                hold_q      <= TxData;
                hold_full_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    busy_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (ss_fall) begin
                        mode_q[MODE_CPOL_BIT] <= CPol;
                        mode_q[MODE_CPHA_BIT] <= CPha;
                        tx_sr_q      <= tx_load_d;
                        underrun_q   <= ~hold_full_q;
                        hold_full_q  <= TxWr;
                        skip_shift_q <= CPha;
                        bit_cnt_q    <= '0;
                        word_done_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        miso_oe_q    <= 1'b1;
                        state_q      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (word_done_q) begin
                        rx_data_q    <= rx_sr_q;
                        rx_valid_q   <= 1'b1;
                        bit_cnt_q    <= '0;
                        word_done_q  <= 1'b0;
                        tx_sr_q      <= tx_load_d;
                        underrun_q   <= ~hold_full_q;
                        hold_full_q  <= TxWr;
                        // Reload stands in for the next tx shift edge in both phases.
                        skip_shift_q <= 1'b1;
                    end else if ((lead_edge_d && !mode_q[MODE_CPHA_BIT]) ||
                                 (trail_edge_d && mode_q[MODE_CPHA_BIT])) begin
                        rx_sr_q   <= {rx_sr_q[DATA_WIDTH-2:0], mosi_lvl};
                        bit_cnt_q <= bit_cnt_q + CW'(1);
                        if (bit_cnt_q == CW'(DATA_WIDTH - 1)) begin
                            word_done_q <= 1'b1;
                        end
                    end else if ((trail_edge_d && !mode_q[MODE_CPHA_BIT]) ||
                                 (lead_edge_d && mode_q[MODE_CPHA_BIT])) begin
                        if (skip_shift_q) begin
                            skip_shift_q <= 1'b0;
                        end else begin
                            tx_sr_q <= {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
                        end
                    end
                    if (ss_rise) begin
                        busy_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                        state_q   <= ST_IDLE;
                        if ((bit_cnt_q != '0) && !word_done_q) begin
                            abort_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign TxReady    = ~hold_full_q;
    assign RxData     = rx_data_q;
    assign RxValid    = rx_valid_q;
    assign TxUnderrun = underrun_q;
    assign Abort      = abort_q;
    assign Busy       = busy_q;
    assign MISO       = tx_sr_q[DATA_WIDTH-1];
    assign MisoOe     = miso_oe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives frames in
// all relevant modes and checks the slave's outputs against fixed values.
module tb_spi_slave;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       CPol, CPha;
    logic [7:0] TxData;
    logic       TxWr;
    logic       TxReady;
    logic [7:0] RxData;
    logic       RxValid, TxUnderrun, Abort, Busy;
    logic       SCK, MOSI, SlaveSelect_n;
    logic       MISO, MisoOe;

    int vectors     = 0;
    int miscompares = 0;

    int         rxv_total = 0;
    int         und_total = 0;
    int         abt_total = 0;
    logic [7:0] rx_log [0:63];

    spi_slave dut (
        .Clk(Clk), .Rst(Rst), .CPol(CPol), .CPha(CPha),
        .TxData(TxData), .TxWr(TxWr), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid), .TxUnderrun(TxUnderrun),
        .Abort(Abort), .Busy(Busy), .SCK(SCK), .MOSI(MOSI),
        .SlaveSelect_n(SlaveSelect_n), .MISO(MISO), .MisoOe(MisoOe)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (RxValid) begin
            rx_log[rxv_total[5:0]] = RxData;
            rxv_total = rxv_total + 1;
        end
        if (TxUnderrun) und_total = und_total + 1;
        if (Abort)      abt_total = abt_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic write_tx(input logic [7:0] d);
        TxData = d;
        TxWr   = 1'b1;
        clk_n(1);
        TxWr   = 1'b0;
    endtask

    task automatic set_mode(input logic pol, input logic pha);
        CPol = pol;
        CPha = pha;
        SCK  = pol;
        clk_n(4);
    endtask

    task automatic select_slave();
        SlaveSelect_n = 1'b0;
        clk_n(6);
    endtask

    task automatic deselect_slave();
        clk_n(4);
        SlaveSelect_n = 1'b1;
        clk_n(6);
    endtask

    // SCK half period is 4 Clk cycles (SCK = Clk/8).
    task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!CPha) begin
                MOSI  = mo[i];
                clk_n(4);
                SCK   = ~CPol;
                mi[i] = MISO;
                clk_n(4);
                SCK   = CPol;
            end else begin
                SCK   = ~CPol;
                MOSI  = mo[i];
                clk_n(4);
                SCK   = CPol;
                mi[i] = MISO;
                clk_n(4);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] mi;
        int rxv0, und0, abt0;

        Rst = 1'b1; CPol = 1'b0; CPha = 1'b0; TxData = 8'h00; TxWr = 1'b0;
        SCK = 1'b0; MOSI = 1'b0; SlaveSelect_n = 1'b1;
        clk_n(3);
        check("reset_flags", {TxReady, RxValid, TxUnderrun, Abort, Busy, MISO, MisoOe}, 7'b1000000);
        check("reset_rxdata", RxData, 8'h00);
        Rst = 1'b0;
        clk_n(4);
        check("idle_flags", {TxReady, RxValid, TxUnderrun, Abort, Busy, MISO, MisoOe}, 7'b1000000);

        // Mode 0
        set_mode(1'b0, 1'b0);
        write_tx(8'hA5);
        check("m0_txready_full", TxReady, 1'b0);
        rxv0 = rxv_total; und0 = und_total;
        select_slave();
        check("m0_busy_oe", {Busy, MisoOe, TxReady}, 3'b111);
        check("m0_no_underrun_at_select", und_total - und0, 0);
        xfer(8'h3C, 8, mi);
        deselect_slave();
        check("m0_miso_word", mi, 8'hA5);
        check("m0_rxdata", RxData, 8'h3C);
        check("m0_rxvalid_count", rxv_total - rxv0, 1);
        check("m0_deselect_flags", {Busy, MisoOe}, 2'b00);

        // Mode 3
        set_mode(1'b1, 1'b1);
        write_tx(8'h5A);
        rxv0 = rxv_total;
        select_slave();
        xfer(8'hC3, 8, mi);
        deselect_slave();
        check("m3_miso_word", mi, 8'h5A);
        check("m3_rxdata", RxData, 8'hC3);
        check("m3_rxvalid_count", rxv_total - rxv0, 1);

        // Back-to-back words under one select
        set_mode(1'b0, 1'b0);
        write_tx(8'h11);
        rxv0 = rxv_total; und0 = und_total;
        select_slave();
        write_tx(8'h22);
        xfer(8'hF0, 8, mi);
        check("b2b_miso_word1", mi, 8'h11);
        xfer(8'h0F, 8, mi);
        check("b2b_miso_word2", mi, 8'h22);
        deselect_slave();
        check("b2b_rxvalid_count", rxv_total - rxv0, 2);
        check("b2b_rx_first", rx_log[rxv0[5:0]], 8'hF0);
        check("b2b_rx_second", rx_log[6'(rxv0 + 1)], 8'h0F);
        // Only the reload after the second word finds the holding register empty.
        check("b2b_underrun_count", und_total - und0, 1);

        // Underrun at select
        rxv0 = rxv_total; und0 = und_total;
        select_slave();
        check("und_pulse_at_select", und_total - und0, 1);
        xfer(8'h5C, 8, mi);
        deselect_slave();
        check("und_miso_word", mi, 8'hFF);
        check("und_rxvalid_count", rxv_total - rxv0, 1);
        check("und_rxdata", RxData, 8'h5C);

        // Abort in mode 1 after 3 bits
        set_mode(1'b0, 1'b1);
        rxv0 = rxv_total; abt0 = abt_total;
        select_slave();
        xfer(8'hE7, 3, mi);
        deselect_slave();
        check("abort_count", abt_total - abt0, 1);
        check("abort_no_rxvalid", rxv_total - rxv0, 0);
        check("abort_rxdata_kept", RxData, 8'h5C);
        check("abort_idle_flags", {Busy, MisoOe}, 2'b00);
        abt0 = abt_total;
        select_slave();
        xfer(8'h81, 8, mi);
        deselect_slave();
        check("post_abort_rxdata", RxData, 8'h81);
        check("clean_deselect_no_abort", abt_total - abt0, 0);

        // Reset mid-word
        set_mode(1'b0, 1'b0);
        write_tx(8'h33);
        rxv0 = rxv_total; und0 = und_total; abt0 = abt_total;
        select_slave();
        xfer(8'hC7, 4, mi);
        Rst = 1'b1;
        SlaveSelect_n = 1'b1;
        SCK = 1'b0;
        clk_n(2);
        check("rst_mid_flags", {TxReady, RxValid, TxUnderrun, Abort, Busy, MISO, MisoOe}, 7'b1000000);
        check("rst_mid_rxdata", RxData, 8'h00);
        Rst = 1'b0;
        clk_n(6);
        check("rst_mid_no_strobes", {rxv_total - rxv0, und_total - und0, abt_total - abt0}, 96'd0);
        check("rst_mid_stays_idle", {Busy, MisoOe}, 2'b00);
        write_tx(8'h96);
        select_slave();
        xfer(8'h96, 8, mi);
        deselect_slave();
        check("rst_fresh_miso_word", mi, 8'h96);
        check("rst_fresh_rxdata", RxData, 8'h96);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI slave endpoint; the responder counterpart to the existing SPI master (spi_regs/spi_cu/shiftreg/pulse_generator).
- Oversamples SCK, SlaveSelect_n and MOSI in the Clk domain and supports all four CPol/CPha modes, MSB first.
- Exposes a one-word transmit holding register and a received-word strobe to local logic.
- Used as the bench partner for spi_top and as the SPI endpoint in peripheral designs.

Parameters:
- DATA_WIDTH, 8, frame length in bits.
- IDLE_WORD, 8'hFF, word shifted out when no transmit data is pending.
- SYNC_STAGES, 2, flip-flop synchronizer depth on SCK, SlaveSelect_n and MOSI (minimum 2).

Ports:
- Clk  in  1  system clock. Only clock; all logic is on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- CPol  in  1  SCK idle level. Sampled only in IDLE.
- CPha  in  1  0: sample on leading edge; 1: sample on trailing edge. Sampled only in IDLE.
- TxData  in  DATA_WIDTH  next word to send.
- TxWr  in  1  writes TxData into the holding register.
- TxReady  out  1  holding register empty.
- RxData  out  DATA_WIDTH  last complete received word.
- RxValid  out  1  one-cycle strobe; RxData is updated.
- TxUnderrun  out  1  one-cycle strobe; IDLE_WORD was loaded instead of TxData.
- Abort  out  1  one-cycle strobe; SlaveSelect_n rose mid-word.
- Busy  out  1  frame in progress (SlaveSelect_n low, after sync).
- SCK  in  1  serial clock from the master.
- MOSI  in  1  serial data from the master.
- SlaveSelect_n  in  1  active-low select from the master.
- MISO  out  1  serial data to the master.
- MisoOe  out  1  MISO output enable. High only while selected.

Behaviour:
- Reset values (Rst=1 at a Clk edge):
  - TxReady=1, RxData=0, RxValid=0, TxUnderrun=0, Abort=0, Busy=0, MISO=0, MisoOe=0.
  - Holding register empty, bit counter 0, state IDLE, latched mode = 0.
  - Synchronizers are preset to the deselected/idle values (SlaveSelect_n=1, SCK=0).
  - Reset mid-frame abandons the frame without strobes. The FSM returns to ACTIVE only after a fresh SlaveSelect_n fall is seen.
- Synchronization and edge detection:
  - SCK, MOSI and SlaveSelect_n each pass through SYNC_STAGES flops.
  - Edges are detected by comparing the synchronized value with a one-cycle-delayed copy.
  - Leading edge = transition away from the latched CPol; trailing edge = transition back to it.
  - Required ratio: Clk frequency >= 8x SCK frequency.
- FSM, IDLE:
  - MisoOe=0, Busy=0.
  - On a synchronized SlaveSelect_n fall:
    - Latch CPol and CPha.
    - Load the tx shift register: holding register if full (TxReady goes 1 the next cycle), else IDLE_WORD with a TxUnderrun pulse.
    - Drive MISO = shift register MSB, set MisoOe=1 and Busy=1.
    - Clear the bit counter and go to ACTIVE.
- FSM, ACTIVE, CPha=0:
  - Sample MOSI into the rx shift register on the leading edge and increment the bit counter.
  - Shift tx on the trailing edge to present the next bit.
- FSM, ACTIVE, CPha=1:
  - Shift tx on the leading edge, except the first leading edge of a word, which keeps the MSB already presented.
  - Sample MOSI on the trailing edge.
- Word completion:
  - When the DATA_WIDTH-th sample lands, in the following cycle: RxData = assembled word, RxValid=1 for one cycle, bit counter back to 0.
  - The tx shift register reloads (holding register or IDLE_WORD plus TxUnderrun), so back-to-back words need no SlaveSelect_n toggle.
  - CPha=0: the reload replaces the final trailing-edge shift, so the new MSB appears on that edge.
- Deselect:
  - A synchronized SlaveSelect_n rise in ACTIVE returns the FSM to IDLE. MisoOe=0 and Busy=0 the next cycle.
  - If the bit counter is nonzero, Abort pulses for one cycle, RxValid does not fire and partial data is discarded.
  - A rise with the counter at 0 (clean word boundary) gives no Abort.
- Holding register:
  - TxWr in any state overwrites it and sets TxReady=0.
  - If TxWr coincides with a load cycle, the load takes the old content (or IDLE_WORD if empty) and the new value stays pending. TxReady=0 after that cycle.
- SCK edges while SlaveSelect_n is high are ignored.
- A mode change while Busy is ignored until the next frame.

Decomposition:
- Shared spi_pkg (constants file): DATA_WIDTH default, IDLE_WORD default, FSM state encodings (IDLE, ACTIVE), mode bit positions shared with spi_regs.
- One sub-module: spi_sync_edge. It takes a SYNC_STAGES-deep synchronizer plus rise/fall detect and outputs the level, rise and fall. Three instances are used (SCK, MOSI level only, SlaveSelect_n).

Test Plan:
- Mode 0 (CPol=0, CPha=0), SCK=Clk/8: TxWr 8'hA5 before select; master sends 8'h3C. Required: master receives 8'hA5, RxData=8'h3C with a single RxValid pulse, TxReady=1 after the select fall, no TxUnderrun.
- Mode 3 (CPol=1, CPha=1): slave holds 8'h5A, master sends 8'hC3. Required: master gets 8'h5A, RxData=8'hC3.
- Back-to-back: 8'h11 held, then TxWr 8'h22 during word 1; master sends 8'hF0, 8'h0F with select low throughout. Required: two RxValid pulses (8'hF0, 8'h0F), master receives 8'h11 then 8'h22.
- Underrun: holding register empty at the select fall. Required: MISO shifts 8'hFF, one TxUnderrun pulse, RxValid still fires.
- Abort: deselect after 3 SCK cycles in mode 1. Required: Abort pulse, no RxValid, RxData unchanged. A following full frame with 8'h81 gives RxData=8'h81.
- Reset mid-word (Rst=1 for 2 cycles after 4 bits): all outputs return to reset values, no strobes. A fresh frame exchanges 8'h96 correctly.
